// File: rtl/multicycle_main_fsm_if.sv
// Instruction-field / control bundle between the main controller and the datapath.
interface multicycle_main_fsm_if;

    localparam int unsigned OP_W    = 2;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned RD_W    = 4;
    localparam int unsigned SEL_W   = 2;

    // instruction fields, taken from the held instruction register
    logic [OP_W-1:0]    op;
    logic [FUNCT_W-1:0] funct;
    logic [RD_W-1:0]    rd;

    // datapath controls
    logic               irwrite;
    logic               nextpc;
    logic               adrsrc;
    logic [SEL_W-1:0]   alusrca;
    logic [SEL_W-1:0]   alusrcb;
    logic [SEL_W-1:0]   resultsrc;
    logic [SEL_W-1:0]   alucontrol;
    logic [SEL_W-1:0]   flagw;

    // conditional-logic requests, gated downstream by the condition check
    logic               pcs;
    logic               regw;
    logic               memw;
    logic               instrdone;

    // controller side
    modport master (
        input  op, funct, rd,
        output irwrite, nextpc, adrsrc, alusrca, alusrcb, resultsrc,
               alucontrol, flagw, pcs, regw, memw, instrdone
    );

    // datapath side
    modport slave (
        output op, funct, rd,
        input  irwrite, nextpc, adrsrc, alusrca, alusrcb, resultsrc,
               alucontrol, flagw, pcs, regw, memw, instrdone
    );

endinterface

// File: rtl/multicycle_main_fsm.sv
// Multicycle ARMv4 main controller: Moore sequencer for DP, LDR/STR and B with
// built-in ALU decoder and PC-write select. Outputs are registered from the
// decode of the next state, so they line up cycle-for-cycle with the state.
module multicycle_main_fsm #(
    parameter int unsigned STATE_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_main_fsm_if.master   bus
);

    localparam int unsigned SEL_W = 2;
    localparam int unsigned CMD_W = 4;
    localparam int unsigned RD_W  = 4;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEMADR   = STATE_W'(2),
        MEMRD    = STATE_W'(3),
        MEMWB    = STATE_W'(4),
        MEMWR    = STATE_W'(5),
        EXECUTER = STATE_W'(6),
        EXECUTEI = STATE_W'(7),
        ALUWB    = STATE_W'(8),
        BRANCH   = STATE_W'(9)
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [CMD_W-1:0] CMD_AND = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_CMP = 4'b1010;
    localparam logic [CMD_W-1:0] CMD_ORR = 4'b1100;

    localparam logic [SEL_W-1:0] ALU_ADD = 2'b00;
    localparam logic [SEL_W-1:0] ALU_SUB = 2'b01;
    localparam logic [SEL_W-1:0] ALU_AND = 2'b10;
    localparam logic [SEL_W-1:0] ALU_ORR = 2'b11;

    localparam logic [RD_W-1:0] RD_PC = 4'hF;

    state_t state;
    state_t next_state;

    logic [CMD_W-1:0] cmd;
    logic             s_bit;
    logic             nowrite;

    // next-cycle output values
    logic             irwrite_d;
    logic             nextpc_d;
    logic             adrsrc_d;
    logic [SEL_W-1:0] alusrca_d;
    logic [SEL_W-1:0] alusrcb_d;
    logic [SEL_W-1:0] resultsrc_d;
    logic [SEL_W-1:0] alucontrol_d;
    logic [SEL_W-1:0] flagw_d;
    logic             aluop_d;
    logic             branch_d;
    logic             regw_d;
    logic             memw_d;
    logic             instrdone_d;
    logic             pcs_d;

    // output registers
    logic             irwrite_q;
    logic             nextpc_q;
    logic             adrsrc_q;
    logic [SEL_W-1:0] alusrca_q;
    logic [SEL_W-1:0] alusrcb_q;
    logic [SEL_W-1:0] resultsrc_q;
    logic [SEL_W-1:0] alucontrol_q;
    logic [SEL_W-1:0] flagw_q;
    logic             pcs_q;
    logic             regw_q;
    logic             memw_q;
    logic             instrdone_q;

    assign cmd     = bus.funct[4:1];
    assign s_bit   = bus.funct[0];
    // compares update flags only; their result is never written back
    assign nowrite = (cmd == CMD_CMP);

    // next-state logic and Moore decode of the state being entered
    always_comb begin
        next_state   = FETCH;
        irwrite_d    = 1'b0;
        nextpc_d     = 1'b0;
        adrsrc_d     = 1'b0;
        alusrca_d    = 2'b00;
        alusrcb_d    = 2'b00;
        resultsrc_d  = 2'b00;
        alucontrol_d = ALU_ADD;
        flagw_d      = 2'b00;
        aluop_d      = 1'b0;
        branch_d     = 1'b0;
        regw_d       = 1'b0;
        memw_d       = 1'b0;
        instrdone_d  = 1'b0;
        pcs_d        = 1'b0;

        unique case (state)
            FETCH:    next_state = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_MEM:  next_state = MEMADR;
                    OP_DP:   next_state = bus.funct[5] ? EXECUTEI : EXECUTER;
                    OP_BR:   next_state = BRANCH;
                    default: next_state = FETCH;
                endcase
            end
            MEMADR:   next_state = s_bit ? MEMRD : MEMWR;
            MEMRD:    next_state = MEMWB;
            EXECUTER: next_state = ALUWB;
            EXECUTEI: next_state = ALUWB;
            default:  next_state = FETCH;
        endcase

        case (next_state)
            FETCH: begin
                irwrite_d   = 1'b1;
                nextpc_d    = 1'b1;
                alusrca_d   = 2'b01;
                alusrcb_d   = 2'b10;
                resultsrc_d = 2'b10;
            end
            DECODE: begin
                alusrca_d   = 2'b01;
                alusrcb_d   = 2'b10;
                resultsrc_d = 2'b10;
            end
            MEMADR: begin
                alusrcb_d   = 2'b01;
            end
            MEMRD: begin
                adrsrc_d    = 1'b1;
            end
            MEMWB: begin
                resultsrc_d = 2'b01;
                regw_d      = 1'b1;
                instrdone_d = 1'b1;
            end
            MEMWR: begin
                adrsrc_d    = 1'b1;
                memw_d      = 1'b1;
                instrdone_d = 1'b1;
            end
            EXECUTER: begin
                aluop_d     = 1'b1;
                alusrcb_d   = 2'b00;
            end
            EXECUTEI: begin
                aluop_d     = 1'b1;
                alusrcb_d   = 2'b01;
            end
            ALUWB: begin
                regw_d      = ~nowrite;
                instrdone_d = 1'b1;
            end
            BRANCH: begin
                alusrca_d   = 2'b10;
                alusrcb_d   = 2'b01;
                resultsrc_d = 2'b10;
                branch_d    = 1'b1;
                instrdone_d = 1'b1;
            end
            default: ;
        endcase

        // ALU decoder: only the execute states select a data-processing op
        if (aluop_d) begin
            case (cmd)
                CMD_ADD: alucontrol_d = ALU_ADD;
                CMD_SUB: alucontrol_d = ALU_SUB;
                CMD_AND: alucontrol_d = ALU_AND;
                CMD_ORR: alucontrol_d = ALU_ORR;
                CMD_CMP: alucontrol_d = ALU_SUB;
                default: alucontrol_d = ALU_ADD;
            endcase
            flagw_d[1] = s_bit;
            flagw_d[0] = s_bit & ((alucontrol_d == ALU_ADD) | (alucontrol_d == ALU_SUB));
        end

        pcs_d = branch_d | (regw_d & (bus.rd == RD_PC));
    end

    // state and output registers, synchronous reset into FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FETCH;
            irwrite_q    <= 1'b1;
            nextpc_q     <= 1'b1;
            adrsrc_q     <= 1'b0;
            alusrca_q    <= 2'b01;
            alusrcb_q    <= 2'b10;
            resultsrc_q  <= 2'b10;
            alucontrol_q <= ALU_ADD;
            flagw_q      <= 2'b00;
            pcs_q        <= 1'b0;
            regw_q       <= 1'b0;
            memw_q       <= 1'b0;
            instrdone_q  <= 1'b0;
        end else begin
            state        <= next_state;
            irwrite_q    <= irwrite_d;
            nextpc_q     <= nextpc_d;
            adrsrc_q     <= adrsrc_d;
            alusrca_q    <= alusrca_d;
            alusrcb_q    <= alusrcb_d;
            resultsrc_q  <= resultsrc_d;
            alucontrol_q <= alucontrol_d;
            flagw_q      <= flagw_d;
            pcs_q        <= pcs_d;
            regw_q       <= regw_d;
            memw_q       <= memw_d;
            instrdone_q  <= instrdone_d;
        end
    end

    assign bus.irwrite    = irwrite_q;
    assign bus.nextpc     = nextpc_q;
    assign bus.adrsrc     = adrsrc_q;
    assign bus.alusrca    = alusrca_q;
    assign bus.alusrcb    = alusrcb_q;
    assign bus.resultsrc  = resultsrc_q;
    assign bus.alucontrol = alucontrol_q;
    assign bus.flagw      = flagw_q;
    assign bus.pcs        = pcs_q;
    assign bus.regw       = regw_q;
    assign bus.memw       = memw_q;
    assign bus.instrdone  = instrdone_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for the multicycle main controller: per-cycle expected control
// vectors are queued when an instruction is presented and popped each cycle.
module tb_multicycle_main_fsm;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    multicycle_main_fsm_if bus ();

    multicycle_main_fsm #(.STATE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {irwrite,nextpc,adrsrc,alusrca,alusrcb,resultsrc,alucontrol,flagw,pcs,regw,memw,instrdone}
    typedef logic [16:0] ovec_t;

    ovec_t exp_q[$];
    string tag_q[$];
    int    n_eval = 0;
    int    n_fail = 0;

    function automatic ovec_t vec(input logic ir, input logic np, input logic adr,
                                  input logic [1:0] sa, input logic [1:0] sb,
                                  input logic [1:0] rs, input logic [1:0] ac,
                                  input logic [1:0] fw, input logic pcs,
                                  input logic rw, input logic mw, input logic dn);
        return {ir, np, adr, sa, sb, rs, ac, fw, pcs, rw, mw, dn};
    endfunction

    function automatic ovec_t observe();
        return {bus.irwrite, bus.nextpc, bus.adrsrc, bus.alusrca, bus.alusrcb,
                bus.resultsrc, bus.alucontrol, bus.flagw, bus.pcs, bus.regw,
                bus.memw, bus.instrdone};
    endfunction

    task automatic check(input string tag, input ovec_t obs, input ovec_t expv);
        n_eval++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %05h expected %05h", tag, obs, expv);
        end
    endtask

    ovec_t v_fetch, v_decode;

    // queue the expected per-cycle outputs of one instruction, ending back in FETCH
    task automatic expect_instr(input string name, input logic [1:0] op,
                                input logic [5:0] funct, input logic [3:0] rd);
        logic [3:0] cmd;
        logic [1:0] ac;
        logic [1:0] fw;
        logic       s;
        logic       rw;
        cmd = funct[4:1];
        s   = funct[0];
        exp_q.push_back(v_decode); tag_q.push_back({name, ".decode"});
        case (op)
            2'b01: begin
                exp_q.push_back(vec(0,0,0,2'b00,2'b01,2'b00,2'b00,2'b00,0,0,0,0));
                tag_q.push_back({name, ".memadr"});
                if (s) begin
                    exp_q.push_back(vec(0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0,0));
                    tag_q.push_back({name, ".memrd"});
                    exp_q.push_back(vec(0,0,0,2'b00,2'b00,2'b01,2'b00,2'b00,(rd == 4'hF),1,0,1));
                    tag_q.push_back({name, ".memwb"});
                end else begin
                    exp_q.push_back(vec(0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,1,1));
                    tag_q.push_back({name, ".memwr"});
                end
            end
            2'b00: begin
                case (cmd)
                    4'b0100: ac = 2'b00;
                    4'b0010: ac = 2'b01;
                    4'b0000: ac = 2'b10;
                    4'b1100: ac = 2'b11;
                    4'b1010: ac = 2'b01;
                    default: ac = 2'b00;
                endcase
                fw = 2'b00;
                if (s) fw = (ac[1] == 1'b0) ? 2'b11 : 2'b10;
                exp_q.push_back(vec(0,0,0,2'b00,(funct[5] ? 2'b01 : 2'b00),2'b00,ac,fw,0,0,0,0));
                tag_q.push_back({name, ".execute"});
                rw = (cmd != 4'b1010);
                exp_q.push_back(vec(0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,(rw && rd == 4'hF),rw,0,1));
                tag_q.push_back({name, ".aluwb"});
            end
            2'b10: begin
                exp_q.push_back(vec(0,0,0,2'b10,2'b01,2'b10,2'b00,2'b00,1,0,0,1));
                tag_q.push_back({name, ".branch"});
            end
            default: ;
        endcase
        exp_q.push_back(v_fetch); tag_q.push_back({name, ".fetch"});
    endtask

    // present an instruction during FETCH and check every following cycle
    task automatic run_instr(input string name, input logic [1:0] op,
                             input logic [5:0] funct, input logic [3:0] rd);
        bus.op    = op;
        bus.funct = funct;
        bus.rd    = rd;
        expect_instr(name, op, funct, rd);
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            check(tag_q.pop_front(), observe(), exp_q.pop_front());
        end
    endtask

    initial begin
        v_fetch  = vec(1,1,0,2'b01,2'b10,2'b10,2'b00,2'b00,0,0,0,0);
        v_decode = vec(0,0,0,2'b01,2'b10,2'b10,2'b00,2'b00,0,0,0,0);

        rst       = 1'b1;
        bus.op    = 2'b00;
        bus.funct = 6'b000000;
        bus.rd    = 4'h0;
        @(posedge clk); #1;
        check("reset", observe(), v_fetch);
        @(posedge clk); #1;
        check("reset_hold", observe(), v_fetch);
        rst = 1'b0;

        run_instr("add_imm_r1", 2'b00, 6'b101000, 4'h1);
        run_instr("add_r1",     2'b00, 6'b001000, 4'h1);
        run_instr("cmp_reg",    2'b00, 6'b010101, 4'h0);
        run_instr("ands",       2'b00, 6'b000001, 4'h2);
        run_instr("sub_reg",    2'b00, 6'b000100, 4'h3);
        run_instr("orrs_imm",   2'b00, 6'b111001, 4'h4);
        run_instr("eors_other", 2'b00, 6'b000011, 4'h5);
        run_instr("ldr",        2'b01, 6'b011001, 4'h6);
        run_instr("ldr_pc",     2'b01, 6'b011001, 4'hF);
        run_instr("str",        2'b01, 6'b011000, 4'h7);
        run_instr("b",          2'b10, 6'b100000, 4'h0);
        run_instr("mov_pc",     2'b00, 6'b111010, 4'hF);
        run_instr("undef",      2'b11, 6'b000000, 4'h8);

        // reset while a load is in MEMRD
        bus.op = 2'b01; bus.funct = 6'b011001; bus.rd = 4'h9;
        @(posedge clk); #1;
        check("rst_ldr.decode", observe(), v_decode);
        @(posedge clk); #1;
        check("rst_ldr.memadr", observe(), vec(0,0,0,2'b00,2'b01,2'b00,2'b00,2'b00,0,0,0,0));
        @(posedge clk); #1;
        check("rst_ldr.memrd", observe(), vec(0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0,0));
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_ldr.fetch", observe(), v_fetch);
        rst = 1'b0;

        // reset while a store is in MEMWR
        bus.op = 2'b01; bus.funct = 6'b011000; bus.rd = 4'hA;
        @(posedge clk); #1;
        check("rst_str.decode", observe(), v_decode);
        @(posedge clk); #1;
        check("rst_str.memadr", observe(), vec(0,0,0,2'b00,2'b01,2'b00,2'b00,2'b00,0,0,0,0));
        @(posedge clk); #1;
        check("rst_str.memwr", observe(), vec(0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,1,1));
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_str.fetch", observe(), v_fetch);
        rst = 1'b0;

        run_instr("add_after_rst", 2'b00, 6'b001001, 4'hB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
